// File: rtl/dvs_pkg.sv
// ----------------------------------------------------------------------------
// dvs_pkg
// Shared types and constants for the DVS event path between uart_rx and
// dvs_gesture_accel.
//   cmd_code_t    : 2-bit control command code
//   CTRL_*        : single-byte control commands recognised between packets
//   parse_state_t : byte-parser states of uart_event_deframer
//   dvs_event_t   : canonical event layout {x, y, pol, ts}. The deframer FIFO
//                   word uses the same field order, with ts TS_WIDTH bits wide.
// Ports: none (package).
// ----------------------------------------------------------------------------
package dvs_pkg;

    localparam int DVS_TS_WIDTH = 16;

    localparam logic [7:0] CTRL_ECHO     = 8'hFF;
    localparam logic [7:0] CTRL_STATUS   = 8'hFE;
    localparam logic [7:0] CTRL_CONFIG   = 8'hFD;
    localparam logic [7:0] CTRL_SOFT_RST = 8'hFC;

    typedef enum logic [1:0] {
        CMD_ECHO     = 2'd0,
        CMD_STATUS   = 2'd1,
        CMD_CONFIG   = 2'd2,
        CMD_SOFT_RST = 2'd3
    } cmd_code_t;

    typedef enum logic [2:0] {
        ST_X_HI = 3'd0,
        ST_X_LO = 3'd1,
        ST_Y_HI = 3'd2,
        ST_Y_LO = 3'd3,
        ST_POL  = 3'd4
    } parse_state_t;

    typedef struct packed {
        logic [8:0]              x;
        logic [8:0]              y;
        logic                    pol;
        logic [DVS_TS_WIDTH-1:0] ts;
    } dvs_event_t;

    // The four control bytes are exactly the values with the top six bits set.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return b[7:2] == 6'b111111;
    endfunction

    // FF->0, FE->1, FD->2, FC->3: the code is the inverted low two bits.
    function automatic cmd_code_t ctrl_to_cmd(input logic [7:0] b);
        return cmd_code_t'(~b[1:0]);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_event_deframer_if.sv
// ----------------------------------------------------------------------------
// uart_event_deframer_if
// Bundles the byte input, event handshake, command strobe and status counters
// of uart_event_deframer.
//   slave  modport : the deframer's view (drives events, commands, status)
//   master modport : the environment's view (drives bytes and event_ready)
// Signals:
//   rx_data[7:0], rx_valid          byte stream from uart_rx
//   event_valid, event_ready        event FIFO head handshake
//   event_x[8:0], event_y[8:0],
//   event_polarity, event_ts        FIFO head contents
//   cmd_valid, cmd_code             one-cycle control command strobe
//   drop_count, oob_count,
//   resync_count                    saturating 8-bit status counters
//   fifo_empty, fifo_full           FIFO status
// ----------------------------------------------------------------------------
interface uart_event_deframer_if
    import dvs_pkg::*;
#(
    parameter int TS_WIDTH = DVS_TS_WIDTH
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                event_valid;
    logic                event_ready;
    logic [8:0]          event_x;
    logic [8:0]          event_y;
    logic                event_polarity;
    logic [TS_WIDTH-1:0] event_ts;
    logic                cmd_valid;
    cmd_code_t           cmd_code;
    logic [7:0]          drop_count;
    logic [7:0]          oob_count;
    logic [7:0]          resync_count;
    logic                fifo_empty;
    logic                fifo_full;

    modport slave (
        input  rx_data, rx_valid, event_ready,
        output event_valid, event_x, event_y, event_polarity, event_ts,
               cmd_valid, cmd_code, drop_count, oob_count, resync_count,
               fifo_empty, fifo_full
    );

    modport master (
        output rx_data, rx_valid, event_ready,
        input  event_valid, event_x, event_y, event_polarity, event_ts,
               cmd_valid, cmd_code, drop_count, oob_count, resync_count,
               fifo_empty, fifo_full
    );
endinterface

// File: rtl/event_fifo_sync.sv
// ----------------------------------------------------------------------------
// event_fifo_sync
// Single-clock FIFO with simultaneous push/pop. The head word is read straight
// from the storage flops, so a pushed word is visible the cycle after the push.
// When empty the head reads as zero so downstream outputs are clean.
// Parameters: WIDTH (word bits), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request / data (ignored when full with no pop)
//   pop               read request (ignored when empty)
//   head_data         oldest word, zero when empty
//   head_valid        FIFO not empty
//   empty, full       status flags
// ----------------------------------------------------------------------------
module event_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             empty,
    output logic             full
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO still accepts a push when a pop frees the slot this cycle.
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    // NOTE: storage has no reset; validity comes from count, and the head mux
    // below hides stale contents, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments in every clocked block, so all state
    // updates see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_event_deframer.sv
// ----------------------------------------------------------------------------
// uart_event_deframer
// Assembles 5-byte packets [X_HI, X_LO, Y_HI, Y_LO, POL] from uart_rx into
// timestamped DVS events, range-checks the coordinates and queues accepted
// events in event_fifo_sync. Between packets the bytes 0xFF/FE/FD/FC are
// decoded into a one-cycle command strobe; 0xFC also clears the counters.
// Parameters:
//   SENSOR_RES      valid coordinates are 0..SENSOR_RES-1 per axis (<= 512)
//   FIFO_DEPTH      event FIFO entries (power of two, >= 2)
//   TS_WIDTH        timestamp width
//   TIMEOUT_CYCLES  inter-byte idle limit for abandoning a partial packet
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             uart_event_deframer_if.slave (bytes in, events/commands/
//                   status out)
// Build option:
//   UART_DEFRAMER_TIMEOUT_EN  enables the idle timeout and resync_count;
//                             otherwise the parser waits indefinitely and
//                             resync_count reads 0.
// ----------------------------------------------------------------------------
module uart_event_deframer
    import dvs_pkg::*;
#(
    parameter int SENSOR_RES     = 320,
    parameter int FIFO_DEPTH     = 4,
    parameter int TS_WIDTH       = DVS_TS_WIDTH,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input logic                  clk,
    input logic                  rst_n,
    uart_event_deframer_if.slave bus
);
    // FIFO word layout matches dvs_event_t: {x, y, pol, ts}.
    localparam int         EVT_W     = 9 + 9 + 1 + TS_WIDTH;
    localparam logic [9:0] RES_LIMIT = SENSOR_RES[9:0];

    logic [TS_WIDTH-1:0] ts_cnt;
    parse_state_t        state;
    parse_state_t        state_next;
    parse_state_t        parse_state;
    logic [8:0]          x_q;
    logic [8:0]          y_q;
    logic                timeout_hit;

    logic                cmd_hit;
    cmd_code_t           cmd_code_d;
    logic                soft_rst_hit;
    logic                evt_oob;
    logic                evt_push;
    logic                evt_drop;
    logic                evt_pop;
    logic                has_room;

    logic                cmd_valid_q;
    cmd_code_t           cmd_code_q;
    logic [7:0]          drop_cnt_q;
    logic [7:0]          oob_cnt_q;

    logic [EVT_W-1:0]    push_word;
    logic [EVT_W-1:0]    head_word;
    logic                head_valid;
    logic                fifo_empty;
    logic                fifo_full;

    // ------------------------------------------------------------------
    // Free-running timestamp, wraps modulo 2^TS_WIDTH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    // A timeout forces the byte arriving in the same cycle to be parsed as
    // X_HI, so the parser acts on this effective state, not the raw register.
    assign parse_state = timeout_hit ? ST_X_HI : state;

    // ------------------------------------------------------------------
    // Parser FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_X_HI;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Parser FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = parse_state;
        if (bus.rx_valid) begin
            unique case (parse_state)
                ST_X_HI: state_next = is_ctrl_byte(bus.rx_data) ? ST_X_HI : ST_X_LO;
                ST_X_LO: state_next = ST_Y_HI;
                ST_Y_HI: state_next = ST_Y_LO;
                ST_Y_LO: state_next = ST_POL;
                ST_POL:  state_next = ST_X_HI;
                default: state_next = ST_X_HI;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parser FSM: outputs (command decode and event disposition)
    // ------------------------------------------------------------------
    assign evt_pop  = head_valid && bus.event_ready;
    assign has_room = !fifo_full || evt_pop;

    always_comb begin
        cmd_hit    = 1'b0;
        cmd_code_d = CMD_ECHO;
        evt_oob    = 1'b0;
        evt_push   = 1'b0;
        evt_drop   = 1'b0;
        if (bus.rx_valid) begin
            unique case (parse_state)
                ST_X_HI: begin
                    if (is_ctrl_byte(bus.rx_data)) begin
                        cmd_hit    = 1'b1;
                        cmd_code_d = ctrl_to_cmd(bus.rx_data);
                    end
                end
                ST_POL: begin
                    evt_oob  = ({1'b0, x_q} >= RES_LIMIT) || ({1'b0, y_q} >= RES_LIMIT);
                    evt_push = !evt_oob && has_room;
                    evt_drop = !evt_oob && !has_room;
                end
                default: ;
            endcase
        end
    end

    assign soft_rst_hit = cmd_hit && (cmd_code_d == CMD_SOFT_RST);

    // Coordinate capture. Each field is fully overwritten before POL, so a
    // packet abandoned part-way leaves nothing that leaks into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (bus.rx_valid) begin
            unique case (parse_state)
                ST_X_HI: if (!is_ctrl_byte(bus.rx_data)) x_q[8] <= bus.rx_data[0];
                ST_X_LO: x_q[7:0] <= bus.rx_data;
                ST_Y_HI: y_q[8]   <= bus.rx_data[0];
                ST_Y_LO: y_q[7:0] <= bus.rx_data;
                default: ;
            endcase
        end
    end

    // Polarity and timestamp come straight from the POL cycle.
    assign push_word = {x_q, y_q, bus.rx_data[0], ts_cnt};

    // ------------------------------------------------------------------
    // Command strobe and saturating counters. A soft reset clear wins over
    // any increment landing in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_ECHO;
            drop_cnt_q  <= '0;
            oob_cnt_q   <= '0;
        end else begin
            cmd_valid_q <= cmd_hit;
            if (cmd_hit) begin
                cmd_code_q <= cmd_code_d;
            end
            if (soft_rst_hit) begin
                drop_cnt_q <= '0;
                oob_cnt_q  <= '0;
            end else begin
                if (evt_drop) drop_cnt_q <= sat_inc8(drop_cnt_q);
                if (evt_oob)  oob_cnt_q  <= sat_inc8(oob_cnt_q);
            end
        end
    end

`ifdef UART_DEFRAMER_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Inter-byte idle timeout: counts idle cycles while a packet is open.
    // ------------------------------------------------------------------
    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = TIMEOUT_CYCLES[IDLE_W-1:0];

    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        resync_cnt_q;

    assign timeout_hit = (state != ST_X_HI) && (idle_cnt == IDLE_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (bus.rx_valid || (state == ST_X_HI) || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resync_cnt_q <= '0;
        end else if (soft_rst_hit) begin
            resync_cnt_q <= '0;
        end else if (timeout_hit) begin
            resync_cnt_q <= sat_inc8(resync_cnt_q);
        end
    end

    assign bus.resync_count = resync_cnt_q;
`else
    assign timeout_hit      = 1'b0;
    assign bus.resync_count = '0;
`endif

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    event_fifo_sync #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (evt_push),
        .push_data  (push_word),
        .pop        (evt_pop),
        .head_data  (head_word),
        .head_valid (head_valid),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign bus.event_valid = head_valid;
    assign {bus.event_x, bus.event_y, bus.event_polarity, bus.event_ts} = head_word;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_code    = cmd_code_q;
    assign bus.drop_count  = drop_cnt_q;
    assign bus.oob_count   = oob_cnt_q;
    assign bus.fifo_empty  = fifo_empty;
    assign bus.fifo_full   = fifo_full;

endmodule

// File: doc/uart_event_deframer.md
# uart_event_deframer

Byte-stream deframer between `uart_rx` and `dvs_gesture_accel`. Assembles 5-byte event packets `[X_HI, X_LO, Y_HI, Y_LO, POL]` into timestamped DVS events and range-checks the coordinates. Buffers events in a small FIFO so that back-pressure from the accelerator does not cause byte-level loss. Decodes the single-byte control commands (0xFF/FE/FD/FC) into a command strobe for the top-level response logic.

## Interface
Parameters:
- `SENSOR_RES`, 320: valid coordinate range is 0..SENSOR_RES-1 on each axis.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of two and ≥2.
- `TS_WIDTH`, 16: timestamp width.
- `TIMEOUT_CYCLES`, 5000: inter-byte idle limit before a partial packet is abandoned.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe, byte valid.
- `event_valid`  out  1  FIFO head valid.
- `event_ready`  in  1  consumer accepts head.
- `event_x`, `event_y`  out  9 each  event coordinates.
- `event_polarity`  out  1  event polarity.
- `event_ts`  out  TS_WIDTH  event timestamp.
- `cmd_valid`  out  1  one-cycle command strobe.
- `cmd_code`  out  2  command code: 0=echo (0xFF), 1=status (0xFE), 2=config (0xFD), 3=soft reset (0xFC).
- `drop_count`  out  8  saturating count of events lost because the FIFO was full.
- `oob_count`  out  8  saturating count of out-of-range events.
- `resync_count`  out  8  saturating count of timeout aborts.
- `fifo_empty`, `fifo_full`  out  1 each  FIFO status.

Reset values:
- All outputs 0, except `fifo_empty` = 1.
- Parser in state X_HI; timestamp counter at 0.

## Operation
- Free-running `ts_cnt` (TS_WIDTH bits) increments every cycle and wraps modulo 2^TS_WIDTH.
- Parser FSM advances only on `rx_valid`.
  - X_HI:
    - 0xFF/FE/FD/FC → assert `cmd_valid` with the matching `cmd_code`; stay in X_HI.
    - Any other byte → store `x[8]` = bit0; go to X_LO.
  - X_LO: store `x[7:0]`; go to Y_HI.
  - Y_HI: store `y[8]` = bit0; go to Y_LO.
  - Y_LO: store `y[7:0]`; go to POL.
  - POL: capture `pol` = bit0 and `ts` = `ts_cnt` in the same cycle; form the event; go to X_HI.
- Control bytes are recognised only in X_HI. In any other state, 0xFC–0xFF are treated as data.
- Event disposition on the POL byte:
  - x ≥ SENSOR_RES or y ≥ SENSOR_RES → discard; increment `oob_count`.
  - Otherwise, FIFO has room → push.
  - Otherwise → discard; increment `drop_count`.
- FIFO "has room" means `!fifo_full`, or a pop occurs in the same cycle (`event_valid && event_ready`).
- Soft reset (0xFC): besides the strobe, clears all three counters in the same cycle. If an increment coincides, the clear wins. 0xFC does not flush the FIFO; the top-level soft reset does that.
- All counters saturate at 255.

## Timing
- Pushed event appears at `event_valid` on the cycle after the POL byte (latency 1).
- Handshake: a transfer occurs when `event_valid && event_ready`. Outputs are held stable while `event_valid && !event_ready`. Events leave the FIFO in arrival order.
- Simultaneous push and pop when full: both occur and occupancy is unchanged.
- Simultaneous push and pop when empty: the event is visible the next cycle, as in the normal case.
- `cmd_valid` asserts the cycle after the control byte's `rx_valid`, for exactly one cycle. It has no handshake.
- Asynchronous reset mid-packet: the partial packet is lost and the FIFO is emptied.

## Configuration
- `UART_DEFRAMER_TIMEOUT_EN` defined:
  - An idle counter runs whenever the parser is not in X_HI, and is cleared by every `rx_valid`.
  - On reaching TIMEOUT_CYCLES, the parser returns to X_HI and `resync_count` increments.
  - A byte arriving in that same cycle is processed as X_HI.
- Undefined: no idle counter; the parser waits indefinitely; `resync_count` is tied to 0.

## Structure
- Shared package `dvs_pkg` holds:
  - the 2-bit command code enum;
  - the control byte constants (8'hFF/FE/FD/FC);
  - the packed event struct `{x[8:0], y[8:0], pol, ts}`.
- Sub-module `event_fifo_sync`: single-clock FIFO with registered head output, full/empty flags, and simultaneous push/pop. Parameterised on width and depth.
- The parser FSM, counters and timeout logic stay in the top of this block.

## Test plan
- Bytes 00 05 00 0A 01, `event_ready`=1 → one event, x=5, y=10, pol=1, `event_ts` equal to `ts_cnt` at the POL byte; FIFO empty afterwards.
- 0xFE while idle → `cmd_valid` for one cycle with `cmd_code`=1; no event. Bytes 01 3F 00 00 00 (x=319) accepted; 01 40 00 00 00 (x=320) rejected with `oob_count`=1.
- `event_ready`=0, six valid packets → first 4 held in order, `drop_count`=2, `fifo_full`=1. Release `event_ready` → 4 events drained in order, then `fifo_empty`=1.
- 0xFF sent as the X_LO byte → treated as data (x[7:0]=0xFF), no `cmd_valid`. Then 0xFC in X_HI → `cmd_code`=3 and all counters read 0.
- With the macro defined: 2 bytes, then idle for 5000 cycles → parser back in X_HI, `resync_count`=1; the next full packet decodes correctly. Without the macro: the same stimulus leaves the parser waiting for Y_HI.
- Deassert `rst_n` asynchronously with 3 events queued and the parser in Y_LO → outputs at reset values immediately; after release, a new packet decodes normally.
